// File: rtl/spi_responder_pkg.sv
// Shared types and constants for the SPI responder shift engine and its
// synchroniser sub-block.
package spi_responder_pkg;

  typedef enum logic [1:0] {
    SPI_MODE0 = 2'd0,
    SPI_MODE1 = 2'd1,
    SPI_MODE2 = 2'd2,
    SPI_MODE3 = 2'd3
  } spi_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2
  } spi_state_t;

  localparam spi_mode_t SUPPORTED_MODE      = SPI_MODE0;
  localparam int        DEFAULT_FRAME_BITS  = 32;
  localparam int        DEFAULT_SYNC_STAGES = 2;

endpackage

// File: rtl/spi_edge_sync.sv
// Multi-flop synchroniser for one asynchronous SPI line, with single-cycle
// rise/fall pulses derived from the synchronised level.
module spi_edge_sync
  import spi_responder_pkg::*;
#(
  parameter int   SyncStages = DEFAULT_SYNC_STAGES,
  parameter logic ResetVal   = 1'b0
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SyncStages-1:0] r_sync;
  logic                  r_prev;

  // Synchroniser chain plus one-cycle-delayed copy for edge detection.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_sync <= {SyncStages{ResetVal}};
      r_prev <= ResetVal;
    end else begin
      r_sync <= {r_sync[SyncStages-2:0], i_async};
      r_prev <= r_sync[SyncStages-1];
    end
  end

  assign o_level = r_sync[SyncStages-1];
  assign o_rise  = r_sync[SyncStages-1] & ~r_prev;
  assign o_fall  = ~r_sync[SyncStages-1] & r_prev;

endmodule

// File: rtl/spi_responder.sv
// SPI mode-0 responder: captures one FrameBits command word from MOSI and
// shifts a pre-loaded response word out on MISO, all oversampled on i_clock.
module spi_responder
  import spi_responder_pkg::*;
#(
  parameter int FrameBits  = DEFAULT_FRAME_BITS,
  parameter int SyncStages = DEFAULT_SYNC_STAGES
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_sclk,
  input  logic                 i_cs_n,
  input  logic                 i_mosi,
  output logic                 o_miso,
  output logic [FrameBits-1:0] o_rx_data,
  output logic                 o_rx_valid,
  output logic                 o_rx_abort,
  input  logic [FrameBits-1:0] i_tx_data,
  input  logic                 i_tx_valid,
  output logic                 o_tx_ready,
  output logic                 o_tx_underrun
);

  localparam int CNT_W    = $clog2(FrameBits + 1);
  localparam int SETTLE_W = $clog2(SyncStages + 1);

  logic w_sclk_rise, w_sclk_fall, w_unused_sclk_level;
  logic w_cs_level, w_cs_rise, w_cs_fall;
  logic w_mosi, w_tx_fire, w_settled;

  logic [SyncStages-1:0] r_mosi_sync;
  spi_state_t            r_state;
  logic [FrameBits-1:0]  r_rx_shreg, r_tx_shreg, r_tx_buf, r_rx_data;
  logic [CNT_W-1:0]      r_bit_cnt;
  logic [SETTLE_W-1:0]   r_settle;
  logic                  r_miso, r_rx_valid, r_rx_abort, r_tx_underrun, r_tx_ready;

  spi_edge_sync #(.SyncStages(SyncStages), .ResetVal(1'b0)) u_sclk_sync (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_async (i_sclk),
    .o_level (w_unused_sclk_level),
    .o_rise  (w_sclk_rise),
    .o_fall  (w_sclk_fall)
  );

  spi_edge_sync #(.SyncStages(SyncStages), .ResetVal(1'b1)) u_cs_sync (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_async (i_cs_n),
    .o_level (w_cs_level),
    .o_rise  (w_cs_rise),
    .o_fall  (w_cs_fall)
  );

  // MOSI needs the same latency as sclk but no edge detection.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_mosi_sync <= {SyncStages{1'b0}};
    end else begin
      r_mosi_sync <= {r_mosi_sync[SyncStages-2:0], i_mosi};
    end
  end

  assign w_mosi    = r_mosi_sync[SyncStages-1];
  assign w_tx_fire = i_tx_valid & r_tx_ready;
  // The cs_n chain holds its reset value until real samples have flushed through.
  assign w_settled = (r_settle == SETTLE_W'(SyncStages));

  // Frame FSM, tx holding buffer and all registered outputs.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state       <= ST_HOLD;
      r_rx_shreg    <= {FrameBits{1'b0}};
      r_tx_shreg    <= {FrameBits{1'b0}};
      r_tx_buf      <= {FrameBits{1'b0}};
      r_rx_data     <= {FrameBits{1'b0}};
      r_bit_cnt     <= {CNT_W{1'b0}};
      r_settle      <= {SETTLE_W{1'b0}};
      r_miso        <= 1'b0;
      r_rx_valid    <= 1'b0;
      r_rx_abort    <= 1'b0;
      r_tx_underrun <= 1'b0;
      r_tx_ready    <= 1'b1;
    end else begin
      r_rx_valid    <= 1'b0;
      r_rx_abort    <= 1'b0;
      r_tx_underrun <= 1'b0;
      if (!w_settled) begin
        r_settle <= r_settle + SETTLE_W'(1);
      end
      if (w_tx_fire) begin
        r_tx_buf   <= i_tx_data;
        r_tx_ready <= 1'b0;
      end
      case (r_state)
        ST_IDLE: begin
          r_miso <= 1'b0;
          if (w_cs_fall) begin
            // No bypass: a same-cycle write only lands in the buffer for the next frame.
            r_state       <= ST_SHIFT;
            r_bit_cnt     <= {CNT_W{1'b0}};
            r_tx_shreg    <= r_tx_ready ? {FrameBits{1'b0}} : r_tx_buf;
            r_miso        <= r_tx_ready ? 1'b0 : r_tx_buf[FrameBits-1];
            r_tx_underrun <= r_tx_ready;
            r_tx_ready    <= ~w_tx_fire;
          end
        end
        ST_SHIFT: begin
          if (w_cs_rise) begin
            r_state    <= ST_IDLE;
            r_miso     <= 1'b0;
            r_rx_abort <= 1'b1;
          end else if (w_sclk_rise) begin
            r_rx_shreg <= {r_rx_shreg[FrameBits-2:0], w_mosi};
            r_bit_cnt  <= r_bit_cnt + CNT_W'(1);
            if (r_bit_cnt == CNT_W'(FrameBits - 1)) begin
              r_rx_data  <= {r_rx_shreg[FrameBits-2:0], w_mosi};
              r_rx_valid <= 1'b1;
              r_state    <= ST_HOLD;
              r_miso     <= 1'b0;
            end
          end else if (w_sclk_fall) begin
            r_tx_shreg <= {r_tx_shreg[FrameBits-2:0], 1'b0};
            r_miso     <= r_tx_shreg[FrameBits-2];
          end
        end
        ST_HOLD: begin
          r_miso <= 1'b0;
          if (w_settled && w_cs_level) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_HOLD;
          r_miso  <= 1'b0;
        end
      endcase
    end
  end

  assign o_miso        = r_miso;
  assign o_rx_data     = r_rx_data;
  assign o_rx_valid    = r_rx_valid;
  assign o_rx_abort    = r_rx_abort;
  assign o_tx_ready    = r_tx_ready;
  assign o_tx_underrun = r_tx_underrun;

endmodule

// File: tb/tb_spi_responder.sv
// Directed bench for spi_responder: the bench plays a mode-0 initiator at
// sclk = clock/8 and checks received words, MISO bits and status pulses.
module tb_spi_responder;

  logic        clk = 1'b0;
  logic        i_reset, i_sclk, i_cs_n, i_mosi, i_tx_valid;
  logic [31:0] i_tx_data;
  logic        o_miso, o_rx_valid, o_rx_abort, o_tx_ready, o_tx_underrun;
  logic [31:0] o_rx_data;

  int n_checks = 0;
  int n_pass   = 0;
  int n_valid  = 0;
  int n_abort  = 0;
  int n_under  = 0;

  spi_responder #(.FrameBits(32), .SyncStages(2)) dut (
    .i_clock       (clk),
    .i_reset       (i_reset),
    .i_sclk        (i_sclk),
    .i_cs_n        (i_cs_n),
    .i_mosi        (i_mosi),
    .o_miso        (o_miso),
    .o_rx_data     (o_rx_data),
    .o_rx_valid    (o_rx_valid),
    .o_rx_abort    (o_rx_abort),
    .i_tx_data     (i_tx_data),
    .i_tx_valid    (i_tx_valid),
    .o_tx_ready    (o_tx_ready),
    .o_tx_underrun (o_tx_underrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (o_rx_valid)    n_valid = n_valid + 1;
    if (o_rx_abort)    n_abort = n_abort + 1;
    if (o_tx_underrun) n_under = n_under + 1;
  end

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks = n_checks + 1;
    if (act === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic tx_push(input logic [31:0] word);
    for (int t = 0; t < 50 && !o_tx_ready; t++) @(negedge clk);
    if (!o_tx_ready) begin
      check_eq("push_ready_timeout", 64'd0, 64'd1);
    end else begin
      i_tx_valid = 1'b1;
      i_tx_data  = word;
      @(negedge clk);
      i_tx_valid = 1'b0;
    end
  endtask

  // Bits are taken MSB-first from bits[63]; the first 32 MISO samples are returned.
  task automatic run_frame(input logic [63:0] bits, input int nbits, input int reset_at,
                           input bit push_mid, input logic [31:0] push_word,
                           output logic [31:0] miso_word);
    miso_word = 32'd0;
    i_cs_n = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (push_mid && k == 1) begin
        check_eq("ready_full_at_start", {63'd0, o_tx_ready}, 64'd0);
        i_tx_valid = 1'b1;
        i_tx_data  = push_word;
      end
      if (push_mid && k == 3) i_tx_valid = 1'b0;
    end
    for (int i = 0; i < nbits; i++) begin
      if (i == reset_at) begin
        i_reset = 1'b1;
        @(negedge clk);
        i_reset = 1'b0;
        check_eq("rst_mid_rx_data", {32'd0, o_rx_data}, 64'd0);
        check_eq("rst_mid_miso", {63'd0, o_miso}, 64'd0);
        check_eq("rst_mid_ready", {63'd0, o_tx_ready}, 64'd1);
        check_eq("rst_mid_valid", {63'd0, o_rx_valid}, 64'd0);
      end
      i_mosi = bits[63-i];
      repeat (4) @(negedge clk);
      if (i < 32) miso_word = {miso_word[30:0], o_miso};
      i_sclk = 1'b1;
      repeat (4) @(negedge clk);
      i_sclk = 1'b0;
    end
    repeat (4) @(negedge clk);
    i_cs_n = 1'b1;
    i_mosi = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  logic [31:0] miso;
  int v0, a0, u0;

  initial begin
    i_reset = 1'b1; i_sclk = 1'b0; i_cs_n = 1'b1; i_mosi = 1'b0;
    i_tx_valid = 1'b0; i_tx_data = 32'd0;
    repeat (3) @(negedge clk);
    check_eq("rst_miso", {63'd0, o_miso}, 64'd0);
    check_eq("rst_rx_data", {32'd0, o_rx_data}, 64'd0);
    check_eq("rst_valid", {63'd0, o_rx_valid}, 64'd0);
    check_eq("rst_abort", {63'd0, o_rx_abort}, 64'd0);
    check_eq("rst_underrun", {63'd0, o_tx_underrun}, 64'd0);
    check_eq("rst_ready", {63'd0, o_tx_ready}, 64'd1);
    i_reset = 1'b0;
    repeat (5) @(negedge clk);

    // 1: preloaded response, normal frame
    tx_push(32'hA5A5_0F0F);
    check_eq("t1_ready_after_push", {63'd0, o_tx_ready}, 64'd0);
    v0 = n_valid; a0 = n_abort; u0 = n_under;
    run_frame({32'hDEAD_BEEF, 32'd0}, 32, -1, 1'b0, 32'd0, miso);
    check_eq("t1_rx_data", {32'd0, o_rx_data}, 64'hDEAD_BEEF);
    check_eq("t1_valid_pulses", 64'(n_valid - v0), 64'd1);
    check_eq("t1_miso", {32'd0, miso}, 64'hA5A5_0F0F);
    check_eq("t1_underrun", 64'(n_under - u0), 64'd0);
    check_eq("t1_abort", 64'(n_abort - a0), 64'd0);
    check_eq("t1_ready_after", {63'd0, o_tx_ready}, 64'd1);

    // 2: empty buffer -> underrun, MISO zero
    v0 = n_valid; u0 = n_under;
    run_frame({32'h0000_0001, 32'd0}, 32, -1, 1'b0, 32'd0, miso);
    check_eq("t2_underrun", 64'(n_under - u0), 64'd1);
    check_eq("t2_miso", {32'd0, miso}, 64'd0);
    check_eq("t2_rx_data", {32'd0, o_rx_data}, 64'h1);
    check_eq("t2_valid_pulses", 64'(n_valid - v0), 64'd1);

    // 3: abort after 17 bits, then a clean frame
    v0 = n_valid; a0 = n_abort;
    run_frame({32'hFFFF_FFFF, 32'd0}, 17, -1, 1'b0, 32'd0, miso);
    check_eq("t3_abort", 64'(n_abort - a0), 64'd1);
    check_eq("t3_no_valid", 64'(n_valid - v0), 64'd0);
    check_eq("t3_rx_kept", {32'd0, o_rx_data}, 64'h1);
    v0 = n_valid;
    run_frame({32'h1234_5678, 32'd0}, 32, -1, 1'b0, 32'd0, miso);
    check_eq("t3_next_rx", {32'd0, o_rx_data}, 64'h1234_5678);
    check_eq("t3_next_valid", 64'(n_valid - v0), 64'd1);

    // 4: 40 sclk cycles, trailing ones ignored
    v0 = n_valid; a0 = n_abort;
    run_frame({32'hCAFE_F00D, 8'hFF, 24'd0}, 40, -1, 1'b0, 32'd0, miso);
    check_eq("t4_rx_data", {32'd0, o_rx_data}, 64'hCAFE_F00D);
    check_eq("t4_valid_pulses", 64'(n_valid - v0), 64'd1);
    check_eq("t4_abort", 64'(n_abort - a0), 64'd0);

    // 5: write during frame-start detection goes to the next frame
    tx_push(32'h2222_2222);
    u0 = n_under;
    run_frame({32'h0F0F_0F0F, 32'd0}, 32, -1, 1'b1, 32'h1111_1111, miso);
    check_eq("t5_miso_first", {32'd0, miso}, 64'h2222_2222);
    check_eq("t5_underrun", 64'(n_under - u0), 64'd0);
    check_eq("t5_ready_held", {63'd0, o_tx_ready}, 64'd0);
    run_frame({32'h0000_0000, 32'd0}, 32, -1, 1'b0, 32'd0, miso);
    check_eq("t5_miso_second", {32'd0, miso}, 64'h1111_1111);

    // 6: reset at bit 10 of a frame
    v0 = n_valid; a0 = n_abort;
    run_frame({32'hFFFF_0000, 32'd0}, 32, 10, 1'b0, 32'd0, miso);
    check_eq("t6_no_valid", 64'(n_valid - v0), 64'd0);
    check_eq("t6_no_abort", 64'(n_abort - a0), 64'd0);
    check_eq("t6_rx_still_reset", {32'd0, o_rx_data}, 64'd0);
    v0 = n_valid;
    run_frame({32'hA0B1_C2D3, 32'd0}, 32, -1, 1'b0, 32'd0, miso);
    check_eq("t6_next_rx", {32'd0, o_rx_data}, 64'hA0B1_C2D3);
    check_eq("t6_next_valid", 64'(n_valid - v0), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
